// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide sequencer.
// Operation codes, FSM states and default latencies.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_if.sv
// E-stage <-> MDU bundle. The cancel wire exists only when
// MDU_CANCEL_EN is defined.
interface mdu_if;

    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
`ifdef MDU_CANCEL_EN
    logic        cancel;
`endif
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
`ifdef MDU_CANCEL_EN
        output cancel,
`endif
        output start, op, a, b,
        input  busy, hi, lo
    );

    modport slave (
`ifdef MDU_CANCEL_EN
        input  cancel,
`endif
        input  start, op, a, b,
        output busy, hi, lo
    );

endinterface

// File: rtl/mdu_arith.sv
// Combinational {hi,lo} result for mult/div ops plus a
// divide-by-zero flag.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res,
    output logic        div_zero
);

    logic               s_ovf;
    logic [31:0]        udvs;
    logic [31:0]        sdvs;
    logic signed [31:0] squo;
    logic signed [31:0] srem;
    logic [31:0]        uquo;
    logic [31:0]        urem;
    logic signed [63:0] smul;
    logic [63:0]        umul;

    assign div_zero = (b == 32'd0);
    assign s_ovf    = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Dividing by 1 instead yields the required MIN/-1 result.
    assign udvs = div_zero ? 32'd1 : b;
    assign sdvs = (div_zero || s_ovf) ? 32'd1 : b;

    assign squo = $signed(a) / $signed(sdvs);
    assign srem = $signed(a) % $signed(sdvs);
    assign uquo = a / udvs;
    assign urem = a % udvs;

    assign smul = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign umul = {32'd0, a} * {32'd0, b};

    always_comb begin
        res = '0;
        unique case (op)
            OP_MULT:  res = smul;
            OP_MULTU: res = umul;
            OP_DIV:   res = {srem, squo};
            OP_DIVU:  res = {urem, uquo};
            default:  res = '0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: latency countdown and HI/LO ownership.
// Optional MDU_CANCEL_EN adds a same-cycle flush of the E-stage op.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input logic clk,
    input logic reset,
    mdu_if.slave bus
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                          MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    mdu_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0] pend_q, pend_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] res;
    logic        div_zero;
    logic        go;

    mdu_arith u_arith (
        .op       (bus.op),
        .a        (bus.a),
        .b        (bus.b),
        .res      (res),
        .div_zero (div_zero)
    );

`ifdef MDU_CANCEL_EN
    assign go = bus.start & ~bus.cancel;
`else
    assign go = bus.start;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    unique case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            pend_d  = res;
                            dz_d    = 1'b0;
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = S_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_d  = res;
                            dz_d    = div_zero;
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = S_BUSY;
                        end
                        OP_MTHI: hi_d = bus.a;
                        OP_MTLO: lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                if (cnt_q == CW'(1)) begin
                    // Divide by zero burns the cycles but commits nothing.
                    if (!dz_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy = (state_q == S_BUSY);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
